// File: rtl/dmem_map_pkg.sv
// Address map of the DMEM responder: peripheral window base, register word
// indices and the bit positions inside STATUS, ALERT and CTRL.
package dmem_map_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'h1000_0000;
  localparam int          MMIO_WIN_BITS  = 5;

  typedef enum logic [2:0] {
    REG_SAMPLE = 3'd0,
    REG_STATUS = 3'd1,
    REG_ALERT  = 3'd2,
    REG_CTRL   = 3'd3,
    REG_CYCLE  = 3'd4
  } reg_sel_e;

  localparam int STATUS_NE_BIT    = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 8;

  localparam int ALERT_FLAG_BIT   = 0;
  localparam int ALERT_CODE_LSB   = 8;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO with a combinationally readable head; flush has priority over
// push and pop, and pointers wrap modulo the power-of-two depth.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [AW:0]   count_d, count_q;
  logic          do_push_s, do_pop_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rdata     = mem[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// DMEM responder: word RAM, sample FIFO window, ALERT/overflow registers.
// Define MMIO_CYCLE_CNT_EN to add the free-running CYCLE counter register.
module dmem_mmio_responder
  import dmem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter int          SMP_W      = 16,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_ADDR
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dmem_en,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  output logic [31:0]      dmem_rdata,
  input  logic             smp_valid,
  input  logic [SMP_W-1:0] smp_data,
  output logic             smp_ready,
  output logic             alert,
  output logic [7:0]       alert_code
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      mem [RAM_WORDS];
  logic [31:0]      mmio_off_s;
  logic             ram_hit_s, mmio_hit_s, ld_s, st_s;
  reg_sel_e         reg_sel_s;
  logic             sel_sample_s, sel_alert_s, sel_ctrl_s;
  logic             fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [SMP_W-1:0] fifo_head_s;
  logic [CW-1:0]    fifo_count_s;
  logic             ovf_d, ovf_q, alert_d, alert_q;
  logic [7:0]       code_d, code_q;
  logic [31:0]      status_s, rdata_s;
  logic             unused_off_s;

  assign ld_s         = dmem_en & ~dmem_we;
  assign st_s         = dmem_en & dmem_we;
  assign ram_hit_s    = (dmem_addr < 32'(RAM_WORDS * 4));
  assign mmio_off_s   = dmem_addr - MMIO_BASE;
  assign mmio_hit_s   = (mmio_off_s[31:MMIO_WIN_BITS] == '0);
  assign reg_sel_s    = reg_sel_e'(mmio_off_s[4:2]);
  assign unused_off_s = ^mmio_off_s[1:0];

  assign sel_sample_s = mmio_hit_s && (reg_sel_s == REG_SAMPLE);
  assign sel_alert_s  = mmio_hit_s && (reg_sel_s == REG_ALERT);
  assign sel_ctrl_s   = mmio_hit_s && (reg_sel_s == REG_CTRL);

  assign fifo_push_s  = smp_valid & ~fifo_full_s;
  assign fifo_pop_s   = ld_s & sel_sample_s & ~fifo_empty_s;
  assign fifo_flush_s = st_s & sel_ctrl_s & dmem_wdata[CTRL_FLUSH_BIT];

  assign smp_ready    = ~fifo_full_s;
  assign alert        = alert_q;
  assign alert_code   = code_q;
  assign dmem_rdata   = rdata_s;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SMP_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push_s),
    .pop    (fifo_pop_s),
    .flush  (fifo_flush_s),
    .wdata  (smp_data),
    .rdata  (fifo_head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .count  (fifo_count_s)
  );

  // RAM write; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (st_s && ram_hit_s && resetn) mem[dmem_addr[RAW+1:2]] <= dmem_wdata;
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic        sel_cycle_s;
  logic [31:0] cycle_d, cycle_q;

  assign sel_cycle_s = mmio_hit_s && (reg_sel_s == REG_CYCLE);

  // Free-running counter, overwritten by a store
  always_comb begin
    if (st_s && sel_cycle_s) cycle_d = dmem_wdata;
    else                     cycle_d = cycle_q + 32'd1;
  end

  // Counter state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycle_q <= 32'd0;
    else         cycle_q <= cycle_d;
  end
`endif

  // Overflow is sticky: a new overflow beats a same-cycle clear
  always_comb begin
    ovf_d   = ovf_q;
    alert_d = alert_q;
    code_d  = code_q;
    if (smp_valid && fifo_full_s) ovf_d = 1'b1;
    else if (st_s && sel_ctrl_s && dmem_wdata[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
    else ovf_d = ovf_q;
    if (st_s && sel_alert_s) begin
      alert_d = dmem_wdata[ALERT_FLAG_BIT];
      code_d  = dmem_wdata[ALERT_CODE_LSB +: 8];
    end else begin
      alert_d = alert_q;
      code_d  = code_q;
    end
  end

  // Overflow and ALERT register state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q   <= 1'b0;
      alert_q <= 1'b0;
      code_q  <= 8'd0;
    end else begin
      ovf_q   <= ovf_d;
      alert_q <= alert_d;
      code_q  <= code_d;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_s                           = 32'd0;
    status_s[STATUS_NE_BIT]            = ~fifo_empty_s;
    status_s[STATUS_FULL_BIT]          = fifo_full_s;
    status_s[STATUS_OVF_BIT]           = ovf_q;
    status_s[STATUS_CNT_LSB +: CW]     = fifo_count_s;
  end

  // Combinational load data; the core samples it in the same cycle
  always_comb begin
    rdata_s = 32'd0;
    if (!ld_s) begin
      rdata_s = 32'd0;
    end else if (ram_hit_s) begin
      rdata_s = mem[dmem_addr[RAW+1:2]];
    end else if (mmio_hit_s) begin
      case (reg_sel_s)
        REG_SAMPLE: rdata_s = fifo_empty_s ? 32'd0
                            : {{(32-SMP_W){fifo_head_s[SMP_W-1]}}, fifo_head_s};
        REG_STATUS: rdata_s = status_s;
        REG_ALERT:  rdata_s = {16'd0, code_q, 7'd0, alert_q};
`ifdef MMIO_CYCLE_CNT_EN
        REG_CYCLE:  rdata_s = cycle_q;
`endif
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

endmodule
